// File: rtl/tick_wait_sequencer.sv
// Waits for a requested number of wait-timer done pulses, then emits a one-cycle
// completion pulse; supports abort and zero-length waits.
//
// state  | meaning
// IDLE   | ready for a request; timer stopped, timer_done ignored
// RUN    | timer running; counting done pulses down to zero
// FINISH | one-cycle completion, wait_done high
module tick_wait_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_ticks,
    output logic             req_ready,
    input  logic             abort,
    output logic             timer_start,
    input  logic             timer_done,
    output logic             busy,
    output logic [CNT_W-1:0] ticks_left,
    output logic             wait_done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            timer_start <= 1'b0;
            busy        <= 1'b0;
            ticks_left  <= '0;
            wait_done   <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            wait_done <= 1'b0;
            aborted   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_ticks != '0) begin
                            state       <= RUN;
                            ticks_left  <= req_ticks;
                            timer_start <= 1'b1;
                        end else begin
                            state     <= FINISH;
                            wait_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The final tick takes priority over a coincident abort.
                    if (timer_done && ticks_left <= CNT_W'(1)) begin
                        state       <= FINISH;
                        ticks_left  <= '0;
                        timer_start <= 1'b0;
                        wait_done   <= 1'b1;
                    end else if (abort) begin
                        state       <= IDLE;
                        ticks_left  <= '0;
                        timer_start <= 1'b0;
                        busy        <= 1'b0;
                        req_ready   <= 1'b1;
                        aborted     <= 1'b1;
                    end else if (timer_done) begin
                        ticks_left <= ticks_left - CNT_W'(1);
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    req_ready   <= 1'b1;
                    timer_start <= 1'b0;
                    busy        <= 1'b0;
                    ticks_left  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_wait_sequencer.sv
// Randomized bench for tick_wait_sequencer: the driver predicts each completion or
// abort pulse and its cycle; a monitor pops and compares when a pulse appears.
module tb_tick_wait_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_ticks;
    logic       req_ready;
    logic       abort;
    logic       timer_start;
    logic       timer_done;
    logic       busy;
    logic [7:0] ticks_left;
    logic       wait_done;
    logic       aborted;

    tick_wait_sequencer #(.CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ticks   (req_ticks),
        .req_ready   (req_ready),
        .abort       (abort),
        .timer_start (timer_start),
        .timer_done  (timer_done),
        .busy        (busy),
        .ticks_left  (ticks_left),
        .wait_done   (wait_done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit is_done;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_done, input int at);
        exp_t e;
        e.is_done = is_done;
        e.cyc     = at;
        exp_q.push_back(e);
    endtask

    // Pulse scoreboard: every wait_done/aborted pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                exp_t m;
                m = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_pulse: got no pulse, expected %s at cycle %0d",
                         m.is_done ? "wait_done" : "aborted", m.cyc);
            end
            if (wait_done || aborted) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got wait_done=%0b aborted=%0b, expected none (cycle %0d)",
                             wait_done, aborted, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind", int'({wait_done, aborted}), e.is_done ? 2 : 1);
                    chk("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic run_txn(input int n, input int gap, input int abort_k, input bit sim_abort);
        int w;
        int pre;
        w = 0;
        while (!req_ready && w < 20) begin
            step();
            w++;
        end
        chk("ready_before_req", int'(req_ready), 1);
        if (!req_ready) return;
        // Stray timer_done/abort while idle must be ignored.
        pre = $urandom_range(0, 2);
        repeat (pre) begin
            timer_done = 1'($urandom_range(0, 1));
            abort      = 1'($urandom_range(0, 1));
            step();
        end
        timer_done = 1'b0;
        abort      = 1'b0;
        chk("ticks_idle", int'(ticks_left), 0);

        req_valid  = 1'b1;
        req_ticks  = 8'(n);
        timer_done = 1'($urandom_range(0, 1));
        abort      = 1'($urandom_range(0, 1));
        if (n == 0) push(1'b1, cyc + 1);
        step();
        req_valid  = 1'b0;
        req_ticks  = 8'($urandom);
        timer_done = 1'b0;
        abort      = 1'b0;
        chk("ready_after_accept", int'(req_ready), 0);
        chk("busy_after_accept", int'(busy), 1);
        if (n == 0) begin
            chk("start_zero_wait", int'(timer_start), 0);
            step();
            chk("ready_after_zero", int'(req_ready), 1);
            chk("busy_after_zero", int'(busy), 0);
            return;
        end
        chk("start_run", int'(timer_start), 1);
        chk("ticks_init", int'(ticks_left), n);

        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap < 0) ? $urandom_range(0, 3) : gap;
            repeat (g) step();
            if (g > 0) chk("ticks_hold", int'(ticks_left), n - i);
            if (i == abort_k) begin
                abort      = 1'b1;
                timer_done = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                push(1'b0, cyc + 1);
                step();
                abort      = 1'b0;
                timer_done = 1'b0;
                chk("start_after_abort", int'(timer_start), 0);
                chk("ticks_after_abort", int'(ticks_left), 0);
                chk("ready_after_abort", int'(req_ready), 1);
                chk("busy_after_abort", int'(busy), 0);
                return;
            end
            timer_done = 1'b1;
            if (i == n - 1) begin
                abort = sim_abort;
                push(1'b1, cyc + 1);
            end
            step();
            timer_done = 1'b0;
            abort      = 1'b0;
            if (i < n - 1) chk("ticks_step", int'(ticks_left), n - i - 1);
        end
        chk("start_finish", int'(timer_start), 0);
        chk("busy_finish", int'(busy), 1);
        chk("ready_finish", int'(req_ready), 0);
        chk("ticks_finish", int'(ticks_left), 0);
        step();
        chk("ready_after_done", int'(req_ready), 1);
        chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_ticks  = '0;
        abort      = 1'b0;
        timer_done = 1'b0;
        step();
        step();
        mon_en = 1'b1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_start", int'(timer_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ticks", int'(ticks_left), 0);
        chk("rst_done", int'(wait_done), 0);
        chk("rst_aborted", int'(aborted), 0);
        reset = 1'b0;
        step();

        run_txn(3, 4, -1, 1'b0);
        run_txn(0, 0, -1, 1'b0);
        run_txn(4, 2, 2, 1'b0);
        run_txn(1, 1, -1, 1'b1);
        run_txn(255, 0, -1, 1'b0);

        // A request held during RUN is accepted only after the current wait completes.
        req_valid = 1'b1;
        req_ticks = 8'd2;
        step();
        req_ticks  = 8'd9;
        timer_done = 1'b1;
        step();
        timer_done = 1'b0;
        chk("held_ticks_dec", int'(ticks_left), 1);
        chk("held_not_accepted", int'(req_ready), 0);
        step();
        step();
        timer_done = 1'b1;
        push(1'b1, cyc + 1);
        step();
        timer_done = 1'b0;
        step();
        step();
        req_valid = 1'b0;
        chk("held_accepted_ticks", int'(ticks_left), 9);
        chk("held_accepted_start", int'(timer_start), 1);
        abort = 1'b1;
        push(1'b0, cyc + 1);
        step();
        abort = 1'b0;

        // Reset mid-RUN with five ticks left.
        req_valid = 1'b1;
        req_ticks = 8'd7;
        step();
        req_valid = 1'b0;
        repeat (2) begin
            timer_done = 1'b1;
            step();
            timer_done = 1'b0;
            step();
        end
        chk("pre_reset_ticks", int'(ticks_left), 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_ready", int'(req_ready), 1);
        chk("midrst_start", int'(timer_start), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ticks", int'(ticks_left), 0);
        chk("midrst_done", int'(wait_done), 0);
        chk("midrst_aborted", int'(aborted), 0);
        step();

        for (int t = 0; t < 150; t++) begin
            int n;
            int ak;
            n  = $urandom_range(0, 6);
            ak = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            run_txn(n, -1, ak, 1'($urandom_range(0, 2) == 0));
        end

        repeat (4) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tick_wait_sequencer.md
Name: tick_wait_sequencer

Overview:
- Control stage directly upstream of the wait timer.
- Accepts a "wait N timer periods" request over a valid/ready handshake and drives the timer's start input.
- Counts the timer's done pulses and emits a one-cycle completion pulse after the Nth.
- Supports abort and zero-length waits, so FSMs upstream can request multi-period delays without counting ticks themselves.

Parameters:
- CNT_W, 8: width of the requested tick count and of the remaining-tick counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ticks  input  CNT_W  number of timer done pulses to wait; sampled on acceptance.
- req_ready  output  1  block can accept a request (high only in IDLE).
- abort  input  1  cancel an in-progress wait.
- timer_start  output  1  drives the timer's start input; high only in RUN.
- timer_done  input  1  single-cycle done pulse from the timer.
- busy  output  1  high in RUN and FINISH.
- ticks_left  output  CNT_W  remaining done pulses in the current wait; 0 when idle.
- wait_done  output  1  one-cycle completion pulse.
- aborted  output  1  one-cycle abort-acknowledge pulse.

Behaviour:
- Reset: synchronous, active-high, and overrides everything, including mid-RUN.
  - State goes to IDLE.
  - req_ready=1; timer_start=0; busy=0; ticks_left=0; wait_done=0; aborted=0.
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- Acceptance: occurs at the rising edge where req_valid=1 and req_ready=1 (state IDLE).
- States:
  - IDLE: req_ready=1; timer_done is ignored.
    - On acceptance with req_ticks!=0: ticks_left<=req_ticks and go to RUN.
    - On acceptance with req_ticks==0: go to FINISH; timer_start is never raised.
  - RUN: timer_start=1; busy=1; req_ready=0.
    - On a timer_done sample with ticks_left>1: ticks_left decrements by 1.
    - On a timer_done sample with ticks_left==1: ticks_left<=0 and go to FINISH.
    - On abort=1 without a final tick: go to IDLE, ticks_left<=0, and pulse aborted for the next cycle.
  - FINISH: lasts exactly one cycle.
    - wait_done=1; timer_start=0; busy=1; req_ready=0.
    - Then go to IDLE.
- Latency:
  - timer_start rises in the cycle after acceptance.
  - wait_done is high in the cycle after the edge that samples the final timer_done.
  - A zero-tick request gives wait_done in the cycle after acceptance.
  - Minimum spacing between back-to-back requests is 2 cycles (FINISH, then IDLE).
- Simultaneous abort and final timer_done in RUN: completion wins. Result is FINISH and wait_done; aborted is not asserted.
- abort in IDLE or FINISH is ignored; aborted stays 0.
- timer_done in IDLE or FINISH is ignored; it does not affect ticks_left.
- The timer holds its count while start is low, so the first period of a wait may be shorter than nominal. Tolerance of one period on the first tick is accepted by design; this block does not compensate.
- req_ticks is sampled only at acceptance; later changes have no effect.
- ticks_left never underflows or wraps. The maximum request (2^CNT_W-1 = 255 with the default) is waited in full.

Test Plan:
- Reset, then req_valid=1 with req_ticks=3 for one cycle.
  - timer_start=1 from the next cycle; ticks_left reads 3.
  - Three timer_done pulses, 5 cycles apart: ticks_left steps 3→2→1→0.
  - wait_done is high for exactly 1 cycle after the third pulse; then req_ready=1 and timer_start=0.
- req_ticks=0 accepted → wait_done high in the very next cycle.
  - timer_start is never asserted; busy is high for 1 cycle.
- req_ticks=4, two timer_done pulses, then abort=1 for one cycle.
  - Next cycle: aborted=1, timer_start=0, ticks_left=0, req_ready=1; wait_done is never asserted.
- req_ticks=1 with abort and timer_done both high on the same edge → wait_done=1, aborted=0.
- During RUN with ticks_left=2: req_valid=1 with req_ticks=9 and a stray timer_done arrive.
  - The request is not accepted and ticks_left goes to 1.
  - After completion, the held req_valid is accepted and ticks_left=9.
- reset asserted mid-RUN (ticks_left=5) for one cycle → next cycle all outputs are at reset values, with no wait_done or aborted pulse.
